// File: rtl/aib_model_pkg.sv
// Shared definitions for the AIB channel model: CSR offsets, ID constant,
// calibration length, link FSM states and the CTRL register layout.
// Optional feature macro: AIB_MODEL_LOOPBACK_EN (enables CTRL.loopback).
package aib_model_pkg;

  // CSR byte offsets. Only address bits [10:0] are decoded.
  localparam logic [10:0] CTRL_OFS   = 11'h200;
  localparam logic [10:0] STATUS_OFS = 11'h204;
  localparam logic [10:0] ID_OFS     = 11'h208;
  localparam logic [10:0] TX_CNT_OFS = 11'h20C;
  localparam logic [10:0] RX_CNT_OFS = 11'h210;

  // The upper 24 bits of the ID register. The low byte is the channel ID.
  localparam logic [23:0] ID_UPPER = 24'hA1B200;

  // Number of cycles the link stays in CALIB before it reaches LINK_UP.
  localparam int unsigned CALIB_CYCLES = 16;

  // Writable CTRL bits. Without the loopback feature, bit2 is held at 0.
  // It then reads 0, and the RX source mux always selects i_rx_bump.
`ifdef AIB_MODEL_LOOPBACK_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CALIB   = 2'd1,
    ST_LINK_UP = 2'd2
  } link_state_e;

  typedef struct packed {
    logic loopback;  // bit2
    logic rx_en;     // bit1
    logic tx_en;     // bit0
  } ctrl_t;

endpackage

// File: rtl/aib_model_csr.sv
// AVMM slave for the AIB channel model. It decodes CTRL, STATUS, ID,
// TX_CNT and RX_CNT. Writes complete at once. Reads stall for one cycle.
// The read data then returns with a one-cycle rdatavld pulse.
// Optional feature macro: AIB_MODEL_LOOPBACK_EN (via CTRL_WMASK).
module aib_model_csr
  import aib_model_pkg::*;
#(
  parameter logic [7:0] CHNL_ID = 8'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [10:0] addr_i,
  input  logic [3:0]  byte_en_i,
  input  logic        write_i,
  input  logic        read_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rdatavld_o,
  output logic        waitreq_o,
  input  logic        link_up_i,
  input  logic        tx_active_i,
  input  logic        rx_active_i,
  input  logic [31:0] tx_cnt_i,
  input  logic [31:0] rx_cnt_i,
  output ctrl_t       ctrl_o
);

  ctrl_t       ctrl_q;
  logic        rd_vld_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;
  logic        rd_accept;

  // CTRL uses only byte lane 0. The other lanes and bits cannot change anything.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{byte_en_i[3:1], wdata_i[31:3]};

  // A read is accepted on its first cycle. The following cycle is the
  // completion cycle, even if the master still holds read high.
  // A write that arrives with a read takes priority, and the read is ignored.
  assign rd_accept = read_i & ~write_i & ~rd_vld_q;
  assign waitreq_o = rd_accept;

  // Read data mux: unmapped offsets return zero.
  always_comb begin
    // NOTE: a default assignment first means no path leaves rd_mux unassigned, so no latch is inferred.
    rd_mux = '0;
    case (addr_i)
      CTRL_OFS:   rd_mux = {29'd0, ctrl_q};
      STATUS_OFS: rd_mux = {29'd0, rx_active_i, tx_active_i, link_up_i};
      ID_OFS:     rd_mux = {ID_UPPER, CHNL_ID};
      TX_CNT_OFS: rd_mux = tx_cnt_i;
      RX_CNT_OFS: rd_mux = rx_cnt_i;
      default:    rd_mux = '0;
    endcase
  end

  // CTRL register: the only writable location. Byte lane 0 holds every implemented bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q <= '0;
    end else if (write_i && (addr_i == CTRL_OFS) && byte_en_i[0]) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      ctrl_q <= ctrl_t'(wdata_i[2:0] & CTRL_WMASK);
    end
  end

  // Read response: the data is captured on accept and presented for one cycle. It is zero otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_vld_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_vld_q <= rd_accept;
      rdata_q  <= rd_accept ? rd_mux : '0;
    end
  end

  assign rdata_o    = rdata_q;
  assign rdatavld_o = rd_vld_q;
  assign ctrl_o     = ctrl_q;

endmodule

// File: rtl/aib_model_top.sv
// AIB channel model top. It holds the link FSM, the registered TX/RX data
// path and the activity counters. The CSR block is instantiated here.
// Optional feature macro: AIB_MODEL_LOOPBACK_EN (RX may source i_data_in).
module aib_model_top
  import aib_model_pkg::*;
#(
  parameter int          DATAWIDTH = 40,
  parameter int unsigned CHNL_ID   = 0
) (
  input  logic                 i_cfg_avmm_clk,
  input  logic                 i_cfg_avmm_rst_n,
  input  logic [16:0]          i_cfg_avmm_addr,
  input  logic [3:0]           i_cfg_avmm_byte_en,
  input  logic                 i_cfg_avmm_write,
  input  logic                 i_cfg_avmm_read,
  input  logic [31:0]          i_cfg_avmm_wdata,
  output logic [31:0]          o_cfg_avmm_rdata,
  output logic                 o_cfg_avmm_rdatavld,
  output logic                 o_cfg_avmm_waitreq,
  input  logic                 i_conf_done,
  input  logic                 ns_mac_rdy,
  input  logic [DATAWIDTH-1:0] i_data_in,
  output logic [DATAWIDTH-1:0] o_tx_bump,
  input  logic [DATAWIDTH-1:0] i_rx_bump,
  output logic [DATAWIDTH-1:0] o_data_out,
  output logic                 o_link_up
);

  localparam logic [3:0] CAL_LAST = 4'(CALIB_CYCLES - 1);

  link_state_e          state_q;
  logic [3:0]           cal_cnt_q;
  logic                 link_up_q;
  logic [31:0]          tx_cnt_q;
  logic [31:0]          rx_cnt_q;
  logic [DATAWIDTH-1:0] tx_q;
  logic [DATAWIDTH-1:0] rx_q;
  logic [DATAWIDTH-1:0] rx_src;
  ctrl_t                ctrl;
  logic                 link_req;
  logic                 tx_active;
  logic                 rx_active;

  // Address bits above [10:0] are not decoded, so the register map aliases.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_cfg_avmm_addr[16:11];

  assign link_req  = i_conf_done & ns_mac_rdy;
  assign tx_active = link_up_q & ctrl.tx_en;
  assign rx_active = link_up_q & ctrl.rx_en;

  // The loopback bit can only be set when the loopback feature is built in.
  assign rx_src = ctrl.loopback ? i_data_in : i_rx_bump;

  // Link FSM. A dropped request returns it to IDLE from any state.
  // CALIB lasts CALIB_CYCLES cycles. o_link_up is registered with the state.
  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      state_q   <= ST_IDLE;
      cal_cnt_q <= '0;
      link_up_q <= 1'b0;
    end else if (!link_req) begin
      state_q   <= ST_IDLE;
      cal_cnt_q <= '0;
      link_up_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_CALIB;
          cal_cnt_q <= '0;
        end
        ST_CALIB: begin
          if (cal_cnt_q == CAL_LAST) begin
            state_q   <= ST_LINK_UP;
            link_up_q <= 1'b1;
          end else begin
            cal_cnt_q <= cal_cnt_q + 4'd1;
          end
        end
        ST_LINK_UP: link_up_q <= 1'b1;
        default: begin
          state_q   <= ST_IDLE;
          link_up_q <= 1'b0;
        end
      endcase
    end
  end

  // Activity counters: they saturate, and they clear once the link is not staying up.
  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else if (!link_up_q || !link_req) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_active && (tx_cnt_q != '1)) tx_cnt_q <= tx_cnt_q + 32'd1;
      if (rx_active && (rx_cnt_q != '1)) rx_cnt_q <= rx_cnt_q + 32'd1;
    end
  end

  // Data path: one-cycle registered pass-through. It outputs zero while inactive.
  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_active ? i_data_in : '0;
      rx_q <= rx_active ? rx_src : '0;
    end
  end

  aib_model_csr #(
    .CHNL_ID (8'(CHNL_ID))
  ) u_csr (
    .clk_i       (i_cfg_avmm_clk),
    .rst_n_i     (i_cfg_avmm_rst_n),
    .addr_i      (i_cfg_avmm_addr[10:0]),
    .byte_en_i   (i_cfg_avmm_byte_en),
    .write_i     (i_cfg_avmm_write),
    .read_i      (i_cfg_avmm_read),
    .wdata_i     (i_cfg_avmm_wdata),
    .rdata_o     (o_cfg_avmm_rdata),
    .rdatavld_o  (o_cfg_avmm_rdatavld),
    .waitreq_o   (o_cfg_avmm_waitreq),
    .link_up_i   (link_up_q),
    .tx_active_i (tx_active),
    .rx_active_i (rx_active),
    .tx_cnt_i    (tx_cnt_q),
    .rx_cnt_i    (rx_cnt_q),
    .ctrl_o      (ctrl)
  );

  assign o_tx_bump  = tx_q;
  assign o_data_out = rx_q;
  assign o_link_up  = link_up_q;

endmodule

// File: tb/tb_aib_model_top.sv
// Directed self-checking bench for aib_model_top (CHNL_ID = 3, DATAWIDTH = 40).
// Expected values depend on whether AIB_MODEL_LOOPBACK_EN is defined.
module tb_aib_model_top;

  localparam int DW = 40;

`ifdef AIB_MODEL_LOOPBACK_EN
  localparam bit          LB       = 1'b1;
  localparam logic [31:0] CTRL_ALL = 32'h0000_0007;
`else
  localparam bit          LB       = 1'b0;
  localparam logic [31:0] CTRL_ALL = 32'h0000_0003;
`endif

  localparam logic [31:0]   ID_EXP  = 32'hA1B2_0003;
  localparam logic [DW-1:0] TX_PAT  = 40'h12_3456_789A;
  localparam logic [DW-1:0] LB_PAT  = 40'h00_0000_00AA;
  localparam logic [DW-1:0] RX_PAT  = 40'h55_0000_1234;

  logic          clk;
  logic          rst_n;
  logic [16:0]   a_addr;
  logic [3:0]    a_be;
  logic          a_write;
  logic          a_read;
  logic [31:0]   a_wdata;
  logic [31:0]   rdata;
  logic          rdatavld;
  logic          waitreq;
  logic          conf_done;
  logic          mac_rdy;
  logic [DW-1:0] data_in;
  logic [DW-1:0] tx_bump;
  logic [DW-1:0] rx_bump;
  logic [DW-1:0] data_out;
  logic          link_up;

  int n_checks = 0;
  int n_fail   = 0;

  aib_model_top #(
    .DATAWIDTH (DW),
    .CHNL_ID   (3)
  ) dut (
    .i_cfg_avmm_clk      (clk),
    .i_cfg_avmm_rst_n    (rst_n),
    .i_cfg_avmm_addr     (a_addr),
    .i_cfg_avmm_byte_en  (a_be),
    .i_cfg_avmm_write    (a_write),
    .i_cfg_avmm_read     (a_read),
    .i_cfg_avmm_wdata    (a_wdata),
    .o_cfg_avmm_rdata    (rdata),
    .o_cfg_avmm_rdatavld (rdatavld),
    .o_cfg_avmm_waitreq  (waitreq),
    .i_conf_done         (conf_done),
    .ns_mac_rdy          (mac_rdy),
    .i_data_in           (data_in),
    .o_tx_bump           (tx_bump),
    .i_rx_bump           (rx_bump),
    .o_data_out          (data_out),
    .o_link_up           (link_up)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge. The write completes at the posedge in between.
  task automatic avmm_write(input logic [16:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_addr  = addr;
    a_wdata = data;
    a_be    = be;
    a_write = 1'b1;
    #1 check("wr_waitreq", {63'd0, waitreq}, 64'd0);
    @(negedge clk);
    a_write = 1'b0;
    a_be    = 4'd0;
  endtask

  // Entered on a negedge. There is one stall cycle, then one valid cycle, then an idle check.
  task automatic avmm_read(input string tag, input logic [16:0] addr, input logic [31:0] exp);
    a_addr = addr;
    a_read = 1'b1;
    #1 check({tag, "_waitreq_hi"}, {63'd0, waitreq}, 64'd1);
    check({tag, "_vld_lo"}, {63'd0, rdatavld}, 64'd0);
    @(negedge clk);
    check({tag, "_waitreq_lo"}, {63'd0, waitreq}, 64'd0);
    check({tag, "_vld_hi"}, {63'd0, rdatavld}, 64'd1);
    check({tag, "_rdata"}, {32'd0, rdata}, {32'd0, exp});
    a_read = 1'b0;
    @(negedge clk);
    check({tag, "_vld_end"}, {63'd0, rdatavld}, 64'd0);
    check({tag, "_rdata_zero"}, {32'd0, rdata}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    a_addr    = '0;
    a_be      = '0;
    a_write   = 1'b0;
    a_read    = 1'b0;
    a_wdata   = '0;
    conf_done = 1'b0;
    mac_rdy   = 1'b0;
    data_in   = '0;
    rx_bump   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdatavld", {63'd0, rdatavld}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_waitreq", {63'd0, waitreq}, 64'd0);
    check("rst_link_up", {63'd0, link_up}, 64'd0);
    check("rst_tx_bump", {24'd0, tx_bump}, 64'd0);
    check("rst_data_out", {24'd0, data_out}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ID register. Upper address bits are ignored, so the alias also hits ID.
    avmm_read("id", 17'h00208, ID_EXP);
    avmm_read("id_alias", 17'h10208, ID_EXP);

    // CTRL byte-lane behaviour
    avmm_write(17'h200, 32'hFFFF_FFFF, 4'b0001);
    avmm_read("ctrl_all", 17'h200, CTRL_ALL);
    avmm_write(17'h200, 32'h0000_0000, 4'b1110);
    avmm_read("ctrl_lane_masked", 17'h200, CTRL_ALL);
    avmm_write(17'h200, 32'h0000_0000, 4'b1111);
    avmm_read("ctrl_clear", 17'h200, 32'h0);

    // RO / unmapped writes are ignored. Unmapped reads return 0.
    avmm_write(17'h208, 32'hFFFF_FFFF, 4'b1111);
    avmm_read("id_ro", 17'h208, ID_EXP);
    avmm_write(17'h20C, 32'h1234_5678, 4'b1111);
    avmm_read("txcnt_ro", 17'h20C, 32'h0);
    avmm_read("unmapped", 17'h300, 32'h0);
    avmm_read("status_idle", 17'h204, 32'h0);

    // Link bring-up: both inputs are required. LINK_UP comes 17 cycles after both are high.
    conf_done = 1'b1;
    repeat (4) @(negedge clk);
    check("link_needs_mac_rdy", {63'd0, link_up}, 64'd0);
    mac_rdy = 1'b1;
    repeat (16) @(negedge clk);
    check("link_up_c16", {63'd0, link_up}, 64'd0);
    @(negedge clk);
    check("link_up_c17", {63'd0, link_up}, 64'd1);
    avmm_read("status_link", 17'h204, 32'h1);

    // TX stream: ten active cycles while CTRL = 3
    avmm_write(17'h200, 32'h3, 4'b0001);
    check("tx_idle_before", {24'd0, tx_bump}, 64'd0);
    data_in = TX_PAT;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("tx_stream", {24'd0, tx_bump}, {24'd0, TX_PAT});
    end
    avmm_write(17'h200, 32'h0, 4'b0001);
    check("tx_stream_last", {24'd0, tx_bump}, {24'd0, TX_PAT});
    @(negedge clk);
    check("tx_off", {24'd0, tx_bump}, 64'd0);
    avmm_read("tx_cnt", 17'h20C, 32'd10);
    avmm_read("rx_cnt", 17'h210, 32'd10);

    // Link drop: IDLE on the next cycle, and the counters clear
    mac_rdy = 1'b0;
    @(negedge clk);
    check("link_drop", {63'd0, link_up}, 64'd0);
    avmm_read("tx_cnt_clr", 17'h20C, 32'd0);
    avmm_read("rx_cnt_clr", 17'h210, 32'd0);
    avmm_read("status_drop", 17'h204, 32'd0);

    // Re-establish the link and exercise the RX path
    mac_rdy = 1'b1;
    repeat (17) @(negedge clk);
    check("relink", {63'd0, link_up}, 64'd1);
    avmm_write(17'h200, 32'h3, 4'b0001);
    data_in = LB_PAT;
    rx_bump = RX_PAT;
    @(negedge clk);
    check("rx_bump_path", {24'd0, data_out}, {24'd0, RX_PAT});
    check("tx_aa", {24'd0, tx_bump}, {24'd0, LB_PAT});
    avmm_read("status_active", 17'h204, 32'h7);

    // Loopback: with i_rx_bump = 0, data_out shows i_data_in only when the feature is built in
    rx_bump = '0;
    avmm_write(17'h200, 32'h7, 4'b0001);
    check("rx_zero", {24'd0, data_out}, 64'd0);
    @(negedge clk);
    check("loopback", {24'd0, data_out}, LB ? {24'd0, LB_PAT} : 64'd0);
    rx_bump = RX_PAT;
    @(negedge clk);
    check("loopback_src", {24'd0, data_out}, LB ? {24'd0, LB_PAT} : {24'd0, RX_PAT});

    // Reset asserted mid-stream, just after a read is accepted
    a_addr = 17'h208;
    a_read = 1'b1;
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    a_read = 1'b0;
    #1;
    check("midrst_tx_bump", {24'd0, tx_bump}, 64'd0);
    check("midrst_data_out", {24'd0, data_out}, 64'd0);
    check("midrst_link_up", {63'd0, link_up}, 64'd0);
    check("midrst_rdatavld", {63'd0, rdatavld}, 64'd0);
    check("midrst_rdata", {32'd0, rdata}, 64'd0);
    check("midrst_waitreq", {63'd0, waitreq}, 64'd0);
    @(negedge clk);
    check("midrst_read_dropped", {63'd0, rdatavld}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_vld", {63'd0, rdatavld}, 64'd0);
    avmm_read("ctrl_post_rst", 17'h200, 32'h0);
    avmm_read("txcnt_post_rst", 17'h20C, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aib_model_top.md
AIB_MODEL_TOP -- requirements
Module: aib_model_top

Interface
REQ-001 Parameter DATAWIDTH, default 40, SHALL set the width of MAC-side and bump-side data.
REQ-002 Parameter CHNL_ID, default 0, SHALL set the value returned in ID register bits[7:0].
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 i_cfg_avmm_clk  input  1  sole clock; all logic samples on its rising edge.
REQ-005 i_cfg_avmm_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_cfg_avmm_addr  input  17  AVMM byte address; only bits[10:0] decoded.
REQ-007 i_cfg_avmm_byte_en  input  4  write byte enables.
REQ-008 i_cfg_avmm_write / i_cfg_avmm_read  input  1 each  AVMM commands; both high together = write only.
REQ-009 i_cfg_avmm_wdata  input  32  write data.
REQ-010 o_cfg_avmm_rdata  output  32  read data; o_cfg_avmm_rdatavld  output  1  read data valid; o_cfg_avmm_waitreq  output  1  stall.
REQ-011 i_conf_done  input  1  configuration complete; ns_mac_rdy  input  1  near-side MAC ready.
REQ-012 i_data_in  input  DATAWIDTH  MAC TX data; o_tx_bump  output  DATAWIDTH  bump TX data.
REQ-013 i_rx_bump  input  DATAWIDTH  bump RX data; o_data_out  output  DATAWIDTH  MAC RX data.
REQ-014 o_link_up  output  1  link state is LINK_UP.

Function
REQ-015 Writes SHALL complete in one cycle with waitreq low; each byte lane is updated only when its byte_en bit is 1.
REQ-016 A read SHALL hold waitreq high for the accept cycle, drop it the next cycle, and pulse rdatavld for exactly one cycle in that next cycle, with rdata valid during the pulse and 0 otherwise.
REQ-017 Registers: 0x200 CTRL RW (bit0 tx_en, bit1 rx_en, bit2 loopback, others read 0); 0x204 STATUS RO (bit0 link_up, bit1 tx_active, bit2 rx_active); 0x208 ID RO = {24'hA1B200, CHNL_ID}; 0x20C TX_CNT RO; 0x210 RX_CNT RO.
REQ-018 Unmapped reads SHALL return 0; writes to unmapped or RO addresses SHALL be ignored.
REQ-019 Link FSM states: IDLE -> CALIB when i_conf_done and ns_mac_rdy are both 1; CALIB lasts exactly 16 cycles -> LINK_UP; any state -> IDLE the cycle after either input drops.
REQ-020 tx_active = link_up & tx_en; o_tx_bump SHALL be i_data_in registered (1-cycle latency) when tx_active, else 0.
REQ-021 rx_active = link_up & rx_en; o_data_out SHALL be i_rx_bump registered (1-cycle latency) when rx_active, else 0; with loopback=1 the source SHALL be i_data_in instead.
REQ-022 TX_CNT/RX_CNT SHALL increment by 1 per active cycle, saturate at 32'hFFFF_FFFF, and clear when the FSM leaves LINK_UP.

Reset
REQ-023 Reset SHALL force: FSM IDLE, CTRL 0, counters 0, all outputs 0 except waitreq 0; a read in flight is dropped (no rdatavld).

Configuration
REQ-024 With AIB_MODEL_LOOPBACK_EN defined, loopback operates per REQ-021; without it, CTRL bit2 reads 0, is unwritable, and RX always sources i_rx_bump.

Structure
REQ-025 Package aib_model_pkg SHALL hold register offsets, the ID constant, calibration length 16, and the FSM state enum.
REQ-026 A sub-module aib_model_csr SHALL implement AVMM decode and registers; link FSM and data path stay in aib_model_top.

Verification
REQ-027 Read 0x208 with CHNL_ID=3 -> waitreq high 1 cycle, then rdatavld with rdata 32'hA1B2_0003.
REQ-028 Write 0x200 wdata 32'hFFFF_FFFF byte_en 4'b0001 -> CTRL reads 32'h0000_0007 (32'h3 without the macro).
REQ-029 Raise i_conf_done and ns_mac_rdy -> o_link_up rises 17 cycles later; drop ns_mac_rdy -> o_link_up 0 next cycle, counters 0.
REQ-030 LINK_UP, CTRL=3, i_data_in=40'h12_3456_789A for 10 cycles -> o_tx_bump matches 1 cycle later; TX_CNT=10.
REQ-031 CTRL=7, i_rx_bump=0, i_data_in=40'hAA -> o_data_out=40'hAA 1 cycle later; reset asserted mid-stream -> all outputs 0 immediately.
